// File: rtl/mux_sel_if.sv
// mux_sel_if: board-side bundle between the switch/button inputs and the mux select.
// Ports: mode, hold, step, sw (master->slave); sel, sel_valid, wrap, state (slave->master).
interface mux_sel_if #(
  parameter int SEL_W = 4
);
  logic             mode;
  logic             hold;
  logic             step;
  logic [SEL_W-1:0] sw;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             wrap;
  logic [1:0]       state;

  modport master (
    output mode,
    output hold,
    output step,
    output sw,
    input  sel,
    input  sel_valid,
    input  wrap,
    input  state
  );

  modport slave (
    input  mode,
    input  hold,
    input  step,
    input  sw,
    output sel,
    output sel_valid,
    output wrap,
    output state
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: drives the board mux select from switches, an auto scan or a stepped pause.
// Ports: clk, rst (sync, active-high); sel_if.slave carries mode/hold/step/sw in, sel/sel_valid/wrap/state out.
module mux_sel_sequencer #(
  parameter int SEL_W = 4,
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = 26
) (
  input  logic      clk,
  input  logic      rst,
  mux_sel_if.slave  sel_if
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_MANUAL = 2'b01,
    S_AUTO   = 2'b10,
    S_PAUSE  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_MAX  = '1;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             valid_q, valid_d;
  logic             step_q;
  logic             step_edge;
  logic             adv;

  assign step_edge = sel_if.step & ~step_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      step_q  <= sel_if.step;
    end
  end

  // Next-state logic: mode beats hold in every active state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = sel_if.mode ? S_AUTO : S_MANUAL;
      end
      S_MANUAL: begin
        if (sel_if.mode) state_d = S_AUTO;
      end
      S_AUTO: begin
        if (!sel_if.mode)     state_d = S_MANUAL;
        else if (sel_if.hold) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (!sel_if.mode)      state_d = S_MANUAL;
        else if (!sel_if.hold) state_d = S_AUTO;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    adv   = 1'b0;
    sel_d = sel_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_MANUAL: begin
        cnt_d = '0;
        // Leaving for AUTO keeps the last manual value
        if (!sel_if.mode) sel_d = sel_if.sw;
      end
      S_AUTO: begin
        if (!sel_if.mode) begin
          sel_d = sel_if.sw;
          cnt_d = '0;
        end else if (!sel_if.hold) begin
          // Step and terminal count together still advance once
          if (step_edge || cnt_q == CNT_LAST) adv = 1'b1;
          else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAUSE: begin
        if (!sel_if.mode) begin
          sel_d = sel_if.sw;
          cnt_d = '0;
        end else if (step_edge) begin
          adv = 1'b1;
        end
      end
      default: begin
        sel_d = '0;
        cnt_d = '0;
      end
    endcase
    if (adv) begin
      sel_d = sel_q + SEL_W'(1);
      cnt_d = '0;
    end
    wrap_d  = adv && (sel_q == SEL_MAX);
    valid_d = (state_d != S_IDLE);
  end

  assign sel_if.sel       = sel_q;
  assign sel_if.sel_valid = valid_q;
  assign sel_if.wrap      = wrap_q;
  assign sel_if.state     = state_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: vector table, directed corner sequences and random run vs. a reference model.
// Drives sel_if as master with DWELL=4.
module tb_mux_sel_sequencer;

  localparam int SEL_W = 4;
  localparam int DWELL = 4;
  localparam int CNT_W = 3;
  localparam int NCODE = 1 << SEL_W;

  localparam int P_IDLE = 0;
  localparam int P_MAN  = 1;
  localparam int P_AUTO = 2;
  localparam int P_PAUS = 3;

  logic clk = 1'b0;
  logic rst;

  mux_sel_if #(.SEL_W(SEL_W)) bus ();

  mux_sel_sequencer #(
    .SEL_W(SEL_W),
    .DWELL(DWELL),
    .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel_if (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the select as a plain counter over NCODE codes
  int m_phase = P_IDLE;
  int m_sel   = 0;
  int m_dwell = 0;
  int m_wrap  = 0;
  int m_prev  = 0;

  typedef struct {
    bit       r;
    bit       mode;
    bit       hold;
    bit       step;
    bit [3:0] sw;
    bit [3:0] sel;
    bit       valid;
    bit       wrap;
    bit [1:0] st;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(bit r, bit m, bit h, bit s, bit [3:0] w);
    rst      = r;
    bus.mode = m;
    bus.hold = h;
    bus.step = s;
    bus.sw   = w;
  endtask

  function automatic void model_advance();
    m_wrap  = (m_sel == NCODE - 1) ? 1 : 0;
    m_sel   = (m_sel + 1) % NCODE;
    m_dwell = 0;
  endfunction

  function automatic void model_clock();
    int edge_seen;
    if (rst) begin
      m_phase = P_IDLE;
      m_sel   = 0;
      m_dwell = 0;
      m_wrap  = 0;
      m_prev  = 0;
      return;
    end
    edge_seen = (bus.step && !m_prev) ? 1 : 0;
    m_prev    = bus.step ? 1 : 0;
    m_wrap    = 0;
    if (m_phase == P_IDLE) begin
      m_phase = bus.mode ? P_AUTO : P_MAN;
    end else if (!bus.mode) begin
      if (m_phase != P_MAN) m_dwell = 0;
      m_phase = P_MAN;
      m_sel   = int'(bus.sw);
    end else if (m_phase == P_MAN) begin
      m_phase = P_AUTO;
      m_dwell = 0;
    end else if (m_phase == P_AUTO) begin
      if (bus.hold) m_phase = P_PAUS;
      else if (edge_seen == 1 || m_dwell == DWELL - 1) model_advance();
      else m_dwell++;
    end else begin
      if (edge_seen == 1) model_advance();
      if (!bus.hold) m_phase = P_AUTO;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic expect4(string tag, int s, int v, int w, int st);
    chk({tag, ".sel"},   32'(bus.sel),       32'(s));
    chk({tag, ".valid"}, 32'(bus.sel_valid), 32'(v));
    chk({tag, ".wrap"},  32'(bus.wrap),      32'(w));
    chk({tag, ".state"}, 32'(bus.state),     32'(st));
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    drive(1, 0, 0, 0, 4'h9);

    //           rst m h s sw     sel v w st
    tbl[0]  = '{1, 0, 0, 0, 4'h9, 4'h0, 0, 0, 2'd0};
    tbl[1]  = '{1, 0, 0, 0, 4'h9, 4'h0, 0, 0, 2'd0};
    tbl[2]  = '{1, 0, 0, 0, 4'h9, 4'h0, 0, 0, 2'd0};
    tbl[3]  = '{0, 0, 0, 0, 4'h9, 4'h0, 1, 0, 2'd1};
    tbl[4]  = '{0, 0, 0, 0, 4'h9, 4'h9, 1, 0, 2'd1};
    tbl[5]  = '{0, 0, 0, 0, 4'hE, 4'hE, 1, 0, 2'd1};
    tbl[6]  = '{0, 1, 0, 0, 4'h0, 4'hE, 1, 0, 2'd2};
    tbl[7]  = '{0, 1, 0, 0, 4'h0, 4'hE, 1, 0, 2'd2};
    tbl[8]  = '{0, 1, 0, 0, 4'h0, 4'hE, 1, 0, 2'd2};
    tbl[9]  = '{0, 1, 0, 0, 4'h0, 4'hE, 1, 0, 2'd2};
    tbl[10] = '{0, 1, 0, 0, 4'h0, 4'hF, 1, 0, 2'd2};
    tbl[11] = '{0, 1, 0, 0, 4'h0, 4'hF, 1, 0, 2'd2};
    tbl[12] = '{0, 1, 0, 0, 4'h0, 4'hF, 1, 0, 2'd2};
    tbl[13] = '{0, 1, 0, 0, 4'h0, 4'hF, 1, 0, 2'd2};
    tbl[14] = '{0, 1, 0, 0, 4'h0, 4'h0, 1, 1, 2'd2};
    tbl[15] = '{0, 1, 0, 0, 4'h0, 4'h0, 1, 0, 2'd2};
    tbl[16] = '{0, 1, 1, 0, 4'h0, 4'h0, 1, 0, 2'd3};
    tbl[17] = '{0, 1, 1, 1, 4'h0, 4'h1, 1, 0, 2'd3};
    tbl[18] = '{0, 1, 1, 0, 4'h0, 4'h1, 1, 0, 2'd3};
    tbl[19] = '{0, 0, 1, 0, 4'h2, 4'h2, 1, 0, 2'd1};
    tbl[20] = '{0, 0, 0, 1, 4'h2, 4'h2, 1, 0, 2'd1};
    tbl[21] = '{0, 0, 0, 0, 4'h2, 4'h2, 1, 0, 2'd1};

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].mode, tbl[i].hold, tbl[i].step, tbl[i].sw);
      tick();
      expect4($sformatf("vec%0d", i), int'(tbl[i].sel), int'(tbl[i].valid),
              int'(tbl[i].wrap), int'(tbl[i].st));
    end

    // Step edge on the terminal-count cycle: one advance only
    drive(1, 1, 0, 0, 4'h0);
    tick();
    drive(0, 1, 0, 0, 4'h0);
    tick();
    expect4("t3.enter", 0, 1, 0, 2);
    ticks(3);
    drive(0, 1, 0, 1, 4'h0);
    tick();
    expect4("t3.step_at_tc", 1, 1, 0, 2);
    drive(0, 1, 0, 0, 4'h0);
    ticks(3);
    chk("t3.dwell_hold", 32'(bus.sel), 32'd1);
    tick();
    chk("t3.next_adv", 32'(bus.sel), 32'd2);

    // Hold at terminal count with sel=3, then step twice in PAUSE
    ticks(4);
    chk("t4.sel3", 32'(bus.sel), 32'd3);
    ticks(3);
    drive(0, 1, 1, 0, 4'h0);
    tick();
    expect4("t4.pause", 3, 1, 0, 3);
    drive(0, 1, 1, 1, 4'h0); tick();
    drive(0, 1, 1, 0, 4'h0); tick();
    drive(0, 1, 1, 1, 4'h0); tick();
    drive(0, 1, 1, 0, 4'h0); tick();
    expect4("t4.steps", 5, 1, 0, 3);
    drive(0, 1, 0, 0, 4'h0);
    tick();
    expect4("t4.resume", 5, 1, 0, 2);
    ticks(3);
    chk("t4.dwell", 32'(bus.sel), 32'd5);
    tick();
    chk("t4.adv", 32'(bus.sel), 32'd6);

    // Reset in the middle of a dwell
    tick();
    drive(1, 1, 0, 0, 4'h9);
    tick();
    expect4("t6.rst", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 4'h9);
    tick();
    expect4("t6.idle_exit", 0, 1, 0, 1);
    tick();
    chk("t6.manual", 32'(bus.sel), 32'h9);

    // Step held through reset: its first edge lands in IDLE and is dropped
    drive(1, 1, 0, 1, 4'h0);
    ticks(2);
    drive(0, 1, 0, 1, 4'h0);
    tick();
    expect4("step_thru_rst", 0, 1, 0, 2);
    tick();
    chk("step_thru_rst.no_adv", 32'(bus.sel), 32'd0);

    // Random run against the model
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit m;
      bit h;
      r = ($urandom_range(0, 149) == 0);
      m = bus.mode;
      h = bus.hold;
      if ($urandom_range(0, 39) == 0) m = ~m;
      if ($urandom_range(0, 14) == 0) h = ~h;
      drive(r, m, h, ($urandom_range(0, 3) == 0), 4'($urandom));
      tick();
      if (bus.sel !== 4'(m_sel) || bus.wrap !== (m_wrap != 0) ||
          bus.state !== 2'(m_phase) ||
          bus.sel_valid !== (m_phase != P_IDLE)) begin
        expect4($sformatf("rand%0d", i), m_sel, (m_phase != P_IDLE) ? 1 : 0,
                m_wrap, m_phase);
      end else begin
        checks++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
